cache_axi_rd_arbiter: RTL and testbench

//  Shares the single AXI read port (AR/R) between icache and dcache refill/uncached reads; one burst in flight at a time.

---
 rtl/cache_axi_rd_arbiter.sv | 171 +++++++++++++++++
 tb/tb_cache_axi_rd_arbiter.sv | 507 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_axi_rd_arbiter.sv
// cache_axi_rd_arbiter: shares one AXI read channel between icache and dcache.
// One burst in flight; dcache reads wait while any dcache write is outstanding.
module cache_axi_rd_arbiter #(
    parameter logic [3:0]  ICACHE_ID = 4'd0,
    parameter logic [3:0]  DCACHE_ID = 4'd1,
    parameter int unsigned WR_CNT_W  = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] i_araddr,
    input  logic [7:0]  i_arlen,
    input  logic        i_arvalid,
    output logic        i_arready,
    output logic [31:0] i_rdata,
    output logic        i_rlast,
    output logic        i_rvalid,
    input  logic        i_rready,

    input  logic [31:0] d_araddr,
    input  logic [7:0]  d_arlen,
    input  logic        d_arvalid,
    output logic        d_arready,
    output logic [31:0] d_rdata,
    output logic        d_rlast,
    output logic        d_rvalid,
    input  logic        d_rready,

    output logic [3:0]  m_arid,
    output logic [31:0] m_araddr,
    output logic [7:0]  m_arlen,
    output logic        m_arvalid,
    input  logic        m_arready,
    input  logic [31:0] m_rdata,
    input  logic        m_rlast,
    input  logic        m_rvalid,
    output logic        m_rready,

    input  logic        m_awvalid,
    input  logic        m_awready,
    input  logic        m_bvalid,
    input  logic        m_bready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        DATA = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    state_t state, state_nxt;
    owner_t owner, owner_nxt;

    // 1: the most recent grant went to dcache, so icache wins the next tie
    logic last_d, last_d_nxt;

    logic [WR_CNT_W-1:0] wr_cnt;
    logic wr_inc, wr_dec;
    logic d_ok, grant_i, grant_d;
    logic in_ar, in_data;
    logic ar_i, ar_d, dt_i, dt_d;

    assign wr_inc = m_awvalid & m_awready;
    assign wr_dec = m_bvalid & m_bready;

    assign d_ok    = d_arvalid & (wr_cnt == '0);
    assign grant_d = (state == IDLE) & d_ok & (~i_arvalid | ~last_d);
    assign grant_i = (state == IDLE) & i_arvalid & ~grant_d;

    assign in_ar   = (state == AR);
    assign in_data = (state == DATA);
    assign ar_i    = in_ar & (owner == OWN_I);
    assign ar_d    = in_ar & (owner == OWN_D);
    assign dt_i    = in_data & (owner == OWN_I);
    assign dt_d    = in_data & (owner == OWN_D);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            owner  <= OWN_NONE;
            last_d <= 1'b0;
        end else begin
            state  <= state_nxt;
            owner  <= owner_nxt;
            last_d <= last_d_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        owner_nxt  = owner;
        last_d_nxt = last_d;
        unique case (state)
            IDLE: begin
                if (grant_d) begin
                    state_nxt  = AR;
                    owner_nxt  = OWN_D;
                    last_d_nxt = 1'b1;
                end else if (grant_i) begin
                    state_nxt  = AR;
                    owner_nxt  = OWN_I;
                    last_d_nxt = 1'b0;
                end
            end
            AR: begin
                if (m_arready) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (m_rvalid & m_rready & m_rlast) begin
                    state_nxt = IDLE;
                    owner_nxt = OWN_NONE;
                end
            end
            default: begin
                state_nxt = IDLE;
                owner_nxt = OWN_NONE;
            end
        endcase
    end

    // Saturating counter; an illegal step is flagged by the assertion below
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_cnt <= '0;
        end else if (wr_inc & ~wr_dec & (wr_cnt != '1)) begin
            wr_cnt <= wr_cnt + 1'b1;
        end else if (wr_dec & ~wr_inc & (wr_cnt != '0)) begin
            wr_cnt <= wr_cnt - 1'b1;
        end
    end

    assign m_arvalid = in_ar;
    assign m_araddr  = ar_i ? i_araddr : (ar_d ? d_araddr : 32'd0);
    assign m_arlen   = ar_i ? i_arlen : (ar_d ? d_arlen : 8'd0);
    assign m_arid    = ar_i ? ICACHE_ID : (ar_d ? DCACHE_ID : 4'd0);
    assign i_arready = ar_i & m_arready;
    assign d_arready = ar_d & m_arready;

    assign m_rready = (dt_i & i_rready) | (dt_d & d_rready);

    assign i_rvalid = dt_i & m_rvalid;
    assign i_rlast  = dt_i & m_rlast;
    assign i_rdata  = dt_i ? m_rdata : 32'd0;
    assign d_rvalid = dt_d & m_rvalid;
    assign d_rlast  = dt_d & m_rlast;
    assign d_rdata  = dt_d ? m_rdata : 32'd0;

    wr_cnt_no_overflow: assert property (
        @(posedge clk) disable iff (!rst)
        !(wr_inc && !wr_dec && (wr_cnt == '1))
    );

    wr_cnt_no_underflow: assert property (
        @(posedge clk) disable iff (!rst)
        !(wr_dec && !wr_inc && (wr_cnt == '0))
    );

    owner_matches_state: assert property (
        @(posedge clk) disable iff (!rst)
        ((state == IDLE) == (owner == OWN_NONE))
    );

endmodule

// File: tb/tb_cache_axi_rd_arbiter.sv
// tb_cache_axi_rd_arbiter: directed scenarios plus random traffic, checked
// every cycle against a transaction-level model of the arbiter.
module tb_cache_axi_rd_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic [31:0] i_araddr = '0;
    logic [7:0]  i_arlen = '0;
    logic        i_arvalid = 1'b0;
    logic        i_arready;
    logic [31:0] i_rdata;
    logic        i_rlast;
    logic        i_rvalid;
    logic        i_rready = 1'b0;

    logic [31:0] d_araddr = '0;
    logic [7:0]  d_arlen = '0;
    logic        d_arvalid = 1'b0;
    logic        d_arready;
    logic [31:0] d_rdata;
    logic        d_rlast;
    logic        d_rvalid;
    logic        d_rready = 1'b0;

    logic [3:0]  m_arid;
    logic [31:0] m_araddr;
    logic [7:0]  m_arlen;
    logic        m_arvalid;
    logic        m_arready = 1'b0;
    logic [31:0] m_rdata = '0;
    logic        m_rlast = 1'b0;
    logic        m_rvalid = 1'b0;
    logic        m_rready;

    logic        m_awvalid = 1'b0;
    logic        m_awready = 1'b0;
    logic        m_bvalid = 1'b0;
    logic        m_bready = 1'b0;

    int tests = 0;
    int fails = 0;

    // model state: owner 0 none / 1 icache / 2 dcache
    int mo_owner = 0;
    bit mo_ar = 1'b0;
    bit mo_tie_d = 1'b1;
    int mo_wr = 0;

    // slave controls
    bit ar_block = 1'b0;
    bit ghost = 1'b0;

    // observation
    int g_ids[$];
    logic [31:0] g_addr[$];
    logic [7:0] g_len[$];
    int grants, lasts, beats_i, beats_d;

    cache_axi_rd_arbiter dut (
        .clk(clk), .rst(rst),
        .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arvalid(i_arvalid),
        .i_arready(i_arready), .i_rdata(i_rdata), .i_rlast(i_rlast),
        .i_rvalid(i_rvalid), .i_rready(i_rready),
        .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arvalid(d_arvalid),
        .d_arready(d_arready), .d_rdata(d_rdata), .d_rlast(d_rlast),
        .d_rvalid(d_rvalid), .d_rready(d_rready),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen),
        .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rlast(m_rlast), .m_rvalid(m_rvalid),
        .m_rready(m_rready),
        .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_bvalid(m_bvalid), .m_bready(m_bready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                         nm, act, exp, $time);
        end
    endtask

    function automatic int idat(input int k);
        if (k < g_ids.size()) return g_ids[k];
        return -1;
    endfunction

    // Per-cycle reference: expectations from model, then advance it
    initial begin : cmp
        bit ei, ed, ar, dt, wi, wd;
        logic [31:0] e_araddr, e_irdata, e_drdata;
        logic [7:0] e_arlen;
        logic [3:0] e_arid;
        bit e_arvalid, e_iarr, e_darr, e_rready;
        bit e_irv, e_irl, e_drv, e_drl;
        int g;
        forever begin
            @(negedge clk);
            if (!rst) begin
                mo_owner = 0;
                mo_ar = 1'b0;
                mo_tie_d = 1'b1;
                mo_wr = 0;
            end
            ei = (mo_owner == 1);
            ed = (mo_owner == 2);
            ar = (mo_owner != 0) && mo_ar;
            dt = (mo_owner != 0) && !mo_ar;
            e_arvalid = ar;
            e_araddr = !ar ? 32'd0 : (ei ? i_araddr : d_araddr);
            e_arlen = !ar ? 8'd0 : (ei ? i_arlen : d_arlen);
            e_arid = (ar && ed) ? 4'd1 : 4'd0;
            e_iarr = ar && ei && m_arready;
            e_darr = ar && ed && m_arready;
            e_rready = dt && (ei ? i_rready : d_rready);
            e_irv = dt && ei && m_rvalid;
            e_irl = dt && ei && m_rlast;
            e_irdata = (dt && ei) ? m_rdata : 32'd0;
            e_drv = dt && ed && m_rvalid;
            e_drl = dt && ed && m_rlast;
            e_drdata = (dt && ed) ? m_rdata : 32'd0;

            chk("m_arvalid", 32'(m_arvalid), 32'(e_arvalid));
            chk("m_araddr", m_araddr, e_araddr);
            chk("m_arlen", 32'(m_arlen), 32'(e_arlen));
            chk("m_arid", 32'(m_arid), 32'(e_arid));
            chk("i_arready", 32'(i_arready), 32'(e_iarr));
            chk("d_arready", 32'(d_arready), 32'(e_darr));
            chk("m_rready", 32'(m_rready), 32'(e_rready));
            chk("i_rvalid", 32'(i_rvalid), 32'(e_irv));
            chk("i_rlast", 32'(i_rlast), 32'(e_irl));
            chk("i_rdata", i_rdata, e_irdata);
            chk("d_rvalid", 32'(d_rvalid), 32'(e_drv));
            chk("d_rlast", 32'(d_rlast), 32'(e_drl));
            chk("d_rdata", d_rdata, e_drdata);

            if (rst) begin
                if (mo_owner == 0) begin
                    wi = i_arvalid;
                    wd = d_arvalid && (mo_wr == 0);
                    if (wi && wd) g = mo_tie_d ? 2 : 1;
                    else if (wi) g = 1;
                    else if (wd) g = 2;
                    else g = 0;
                    if (g != 0) begin
                        mo_owner = g;
                        mo_ar = 1'b1;
                        mo_tie_d = (g == 1);
                    end
                end else if (mo_ar) begin
                    if (m_arready) mo_ar = 1'b0;
                end else if (m_rvalid && e_rready && m_rlast) begin
                    mo_owner = 0;
                end
                if (m_awvalid && m_awready) mo_wr++;
                if (m_bvalid && m_bready) mo_wr--;
            end
        end
    end

    // AXI read slave: beats follow the AR length it accepted
    initial begin : slave
        bit arh, rh;
        int alen, s_left;
        bit s_act;
        s_left = 0;
        s_act = 1'b0;
        forever begin
            @(negedge clk);
            arh = m_arvalid && m_arready;
            alen = int'(m_arlen);
            rh = m_rvalid && m_rready;
            @(posedge clk);
            #1;
            if (!rst) begin
                s_act = 1'b0;
                s_left = 0;
            end else begin
                if (rh && s_act) begin
                    s_left--;
                    if (s_left == 0) s_act = 1'b0;
                end
                if (arh) begin
                    s_act = 1'b1;
                    s_left = alen + 1;
                end
            end
            m_arready = !ar_block && ($urandom_range(0, 3) != 0);
            if (ghost) begin
                m_rvalid = 1'b1;
                m_rlast = 1'b0;
                m_rdata = $urandom;
            end else if (!s_act) begin
                m_rvalid = 1'b0;
                m_rlast = 1'b0;
                m_rdata = '0;
            end else if (!m_rvalid || rh) begin
                m_rvalid = ($urandom_range(0, 3) != 0);
                m_rdata = $urandom;
                m_rlast = (s_left == 1);
            end
        end
    end

    initial begin : watchdog
        #1000000;
        fails++;
        $display("FAIL global_timeout: got running, expected finished");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        g_ids.delete();
        g_addr.delete();
        g_len.delete();
        grants = 0;
        lasts = 0;
        beats_i = 0;
        beats_d = 0;
    endtask

    task automatic step();
        bit ih, dh;
        @(negedge clk);
        ih = i_arvalid && i_arready;
        dh = d_arvalid && d_arready;
        if (m_arvalid && m_arready) begin
            g_ids.push_back(int'(m_arid));
            g_addr.push_back(m_araddr);
            g_len.push_back(m_arlen);
            grants++;
        end
        if (i_rvalid && i_rready) begin
            beats_i++;
            if (i_rlast) lasts++;
        end
        if (d_rvalid && d_rready) begin
            beats_d++;
            if (d_rlast) lasts++;
        end
        cyc();
        if (ih) i_arvalid = 1'b0;
        if (dh) d_arvalid = 1'b0;
    endtask

    task automatic watch(input int max, input bit until_idle);
        for (int n = 0; n < max; n++) begin
            step();
            if (until_idle && !i_arvalid && !d_arvalid && grants == lasts)
                return;
        end
        if (until_idle) begin
            tests++;
            fails++;
            $display("FAIL watch_timeout: got busy after %0d cycles, expected idle", max);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        i_arvalid = 1'b0;
        d_arvalid = 1'b0;
        i_rready = 1'b0;
        d_rready = 1'b0;
        m_awvalid = 1'b0;
        m_awready = 1'b0;
        m_bvalid = 1'b0;
        m_bready = 1'b0;
        ghost = 1'b0;
        ar_block = 1'b0;
        repeat (2) cyc();
        rst = 1'b1;
        cyc();
    endtask

    initial begin : main
        bit ih, dh, awh, bh;
        int outw, n;

        // reset state
        @(negedge clk);
        chk("reset_arvalid", 32'(m_arvalid), 32'd0);
        chk("reset_rready", 32'(m_rready), 32'd0);
        chk("reset_i_rvalid", 32'(i_rvalid), 32'd0);
        chk("reset_d_arready", 32'(d_arready), 32'd0);
        cyc();
        do_reset();

        // icache-only 8-beat burst
        clear_obs();
        i_araddr = 32'hBFC0_0000;
        i_arlen = 8'd7;
        i_arvalid = 1'b1;
        i_rready = 1'b1;
        watch(200, 1'b1);
        chk("ionly_grants", 32'(grants), 32'd1);
        chk("ionly_id", 32'(idat(0)), 32'd0);
        if (g_addr.size() > 0) chk("ionly_addr", g_addr[0], 32'hBFC0_0000);
        if (g_len.size() > 0) chk("ionly_len", 32'(g_len[0]), 32'd7);
        chk("ionly_beats", 32'(beats_i), 32'd8);
        chk("ionly_dbeats", 32'(beats_d), 32'd0);
        @(negedge clk);
        chk("ionly_idle_arvalid", 32'(m_arvalid), 32'd0);
        chk("ionly_idle_rready", 32'(m_rready), 32'd0);
        cyc();

        // ties: dcache first after reset, then alternate
        do_reset();
        clear_obs();
        i_araddr = 32'h0000_1000;
        i_arlen = 8'd3;
        d_araddr = 32'h0000_2000;
        d_arlen = 8'd1;
        i_rready = 1'b1;
        d_rready = 1'b1;
        i_arvalid = 1'b1;
        d_arvalid = 1'b1;
        watch(300, 1'b1);
        chk("tie1_grants", 32'(grants), 32'd2);
        chk("tie1_first", 32'(idat(0)), 32'd1);
        chk("tie1_second", 32'(idat(1)), 32'd0);
        chk("tie1_ibeats", 32'(beats_i), 32'd4);
        chk("tie1_dbeats", 32'(beats_d), 32'd2);
        clear_obs();
        i_arvalid = 1'b1;
        d_arvalid = 1'b1;
        watch(300, 1'b1);
        chk("tie2_first", 32'(idat(0)), 32'd1);
        chk("tie2_second", 32'(idat(1)), 32'd0);

        // outstanding write blocks dcache only
        do_reset();
        clear_obs();
        m_awvalid = 1'b1;
        m_awready = 1'b1;
        cyc();
        m_awvalid = 1'b0;
        m_awready = 1'b0;
        d_araddr = 32'h0000_3000;
        d_arlen = 8'd2;
        d_arvalid = 1'b1;
        d_rready = 1'b1;
        watch(10, 1'b0);
        chk("wblk_none", 32'(grants), 32'd0);
        i_araddr = 32'h0000_4000;
        i_arlen = 8'd1;
        i_arvalid = 1'b1;
        i_rready = 1'b1;
        watch(80, 1'b0);
        chk("wblk_igrant", 32'(grants), 32'd1);
        chk("wblk_iid", 32'(idat(0)), 32'd0);
        chk("wblk_ibeats", 32'(beats_i), 32'd2);
        chk("wblk_dbeats", 32'(beats_d), 32'd0);
        m_awvalid = 1'b1;
        m_awready = 1'b1;
        m_bvalid = 1'b1;
        m_bready = 1'b1;
        cyc();
        m_awvalid = 1'b0;
        m_awready = 1'b0;
        m_bvalid = 1'b0;
        m_bready = 1'b0;
        watch(10, 1'b0);
        chk("wblk_still", 32'(grants), 32'd1);
        m_bvalid = 1'b1;
        m_bready = 1'b1;
        cyc();
        m_bvalid = 1'b0;
        m_bready = 1'b0;
        clear_obs();
        watch(100, 1'b1);
        chk("wblk_dgrant", 32'(grants), 32'd1);
        chk("wblk_did", 32'(idat(0)), 32'd1);
        if (g_addr.size() > 0) chk("wblk_daddr", g_addr[0], 32'h0000_3000);
        chk("wblk_dbeats2", 32'(beats_d), 32'd3);

        // AR stall stability, then requester backpressure
        do_reset();
        clear_obs();
        ar_block = 1'b1;
        cyc();
        i_araddr = 32'h0000_5000;
        i_arlen = 8'd3;
        i_arvalid = 1'b1;
        i_rready = 1'b1;
        cyc();
        repeat (5) begin
            @(negedge clk);
            chk("stall_arvalid", 32'(m_arvalid), 32'd1);
            chk("stall_addr", m_araddr, 32'h0000_5000);
            chk("stall_len", 32'(m_arlen), 32'd3);
            chk("stall_arready", 32'(i_arready), 32'd0);
            cyc();
        end
        ar_block = 1'b0;
        n = 0;
        while (beats_i == 0 && n < 100) begin
            step();
            n++;
        end
        chk("bp_first_beat", 32'(beats_i), 32'd1);
        i_rready = 1'b0;
        repeat (4) begin
            step();
            chk("bp_rready", 32'(m_rready), 32'd0);
        end
        i_rready = 1'b1;
        watch(100, 1'b1);
        chk("bp_beats", 32'(beats_i), 32'd4);
        chk("bp_grants", 32'(grants), 32'd1);

        // reset in the middle of an 8-beat burst
        do_reset();
        clear_obs();
        m_awvalid = 1'b1;
        m_awready = 1'b1;
        cyc();
        m_awvalid = 1'b0;
        m_awready = 1'b0;
        i_araddr = 32'h0000_6000;
        i_arlen = 8'd7;
        i_arvalid = 1'b1;
        i_rready = 1'b1;
        n = 0;
        while (beats_i < 2 && n < 100) begin
            step();
            n++;
        end
        chk("mid_beats_before", 32'(beats_i), 32'd2);
        rst = 1'b0;
        ghost = 1'b1;
        i_arvalid = 1'b0;
        @(negedge clk);
        chk("mid_rst_i_rvalid", 32'(i_rvalid), 32'd0);
        chk("mid_rst_rready", 32'(m_rready), 32'd0);
        chk("mid_rst_arvalid", 32'(m_arvalid), 32'd0);
        chk("mid_rst_i_rdata", i_rdata, 32'd0);
        cyc();
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("ghost_rready", 32'(m_rready), 32'd0);
            chk("ghost_i_rvalid", 32'(i_rvalid), 32'd0);
            cyc();
        end
        ghost = 1'b0;
        cyc();
        clear_obs();
        d_araddr = 32'h0000_7000;
        d_arlen = 8'd0;
        d_arvalid = 1'b1;
        d_rready = 1'b1;
        watch(100, 1'b1);
        chk("post_rst_dgrant", 32'(idat(0)), 32'd1);
        chk("post_rst_dbeats", 32'(beats_d), 32'd1);

        // random traffic against the model
        do_reset();
        outw = 0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            ih = i_arvalid && i_arready;
            dh = d_arvalid && d_arready;
            awh = m_awvalid && m_awready;
            bh = m_bvalid && m_bready;
            cyc();
            if (awh) outw++;
            if (bh) outw--;
            if (ih || !i_arvalid) begin
                i_arvalid = ($urandom_range(0, 2) == 0);
                i_araddr = $urandom;
                i_arlen = 8'($urandom_range(0, 7));
            end else if (mo_owner == 0 && $urandom_range(0, 15) == 0) begin
                i_arvalid = 1'b0;
            end
            if (dh || !d_arvalid) begin
                d_arvalid = ($urandom_range(0, 2) == 0);
                d_araddr = $urandom;
                d_arlen = 8'($urandom_range(0, 7));
            end else if (mo_owner == 0 && $urandom_range(0, 15) == 0) begin
                d_arvalid = 1'b0;
            end
            i_rready = ($urandom_range(0, 3) != 0);
            d_rready = ($urandom_range(0, 3) != 0);
            m_awvalid = (outw < 3) && ($urandom_range(0, 5) == 0);
            m_awready = ($urandom_range(0, 1) == 0);
            m_bvalid = (outw > 0) && ($urandom_range(0, 4) == 0);
            m_bready = ($urandom_range(0, 1) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
